johnson_seq_checker: RTL
========================

JOHNSON_SEQ_CHECKER -- requirements
Module: johnson_seq_checker

Interface
REQ-001 Parameter: LOCK_CNT, 2, consecutive correct transitions required in VERIFY before entering LOCKED (legal range 1..15).
REQ-002 Parameter: ERR_W, 8, width of the saturating error counter.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  synchronous active-high reset.
REQ-006 Port: cen  input  1  sample strobe; count_in is evaluated only in cycles where cen=1.
REQ-007 Port: load  input  1  generator-load indication; qualified by cen; forces resynchronisation.
REQ-008 Port: count_in  input  6  observed twisted-ring (Johnson) counter state.
REQ-009 Port: err_clr  input  1  clears err_count.
REQ-010 Port: locked  output  1  high while the FSM is in LOCKED.
REQ-011 Port: index  output  4  decoded sequence position (0..11) of the last legal sample.
REQ-012 Port: invalid  output  1  one-cycle pulse; the sample was not one of the 12 legal codes.
REQ-013 Port: err  output  1  one-cycle pulse; sequence break detected while LOCKED.
REQ-014 Port: wrap  output  1  one-cycle pulse; LOCKED and index went from 11 to 0.
REQ-015 Port: err_count  output  ERR_W  saturating count of err pulses.

Function
REQ-016 Generator rule being checked SHALL be: next = {~q[0], q[5:1]} (shift right, inverted LSB into MSB).
REQ-017 Legal codes and indices SHALL be: 000000=0, 100000=1, 110000=2, 111000=3, 111100=4, 111110=5, 111111=6, 011111=7, 001111=8, 000111=9, 000011=10, 000001=11; the other 52 codes are illegal.
REQ-018 All outputs SHALL be registered; the response to a sample at edge N SHALL appear after edge N+1 (1-cycle latency).
REQ-019 Cycles with cen=0 SHALL hold the state, the reference, the match count, index, locked, and err_count; invalid, err, and wrap SHALL be 0.
REQ-020 FSM states SHALL be HUNT, VERIFY, and LOCKED; an internal reference register SHALL hold the last legal sample.
REQ-021 HUNT: a legal sample SHALL load the reference, clear the match count, and go to VERIFY; an illegal sample SHALL stay in HUNT and pulse invalid.
REQ-022 VERIFY: sample == next(reference) SHALL increment the match count; when the count reaches LOCK_CNT, the FSM SHALL go to LOCKED.
REQ-023 VERIFY: a legal mismatch SHALL stay in VERIFY, clear the match count, and reload the reference; an illegal sample SHALL pulse invalid and go to HUNT.
REQ-024 LOCKED: a match SHALL stay in LOCKED; a mismatch SHALL pulse err, increment err_count, and go to HUNT; an illegal sample SHALL also pulse invalid.
REQ-025 cen=1 with load=1 SHALL override REQ-021..024 in any state: a legal sample goes to VERIFY with the reference loaded and the count cleared; an illegal sample goes to HUNT with invalid pulsed; err SHALL never pulse on a load sample.
REQ-026 index SHALL update on every legal sample and hold its value on illegal samples.
REQ-027 wrap SHALL pulse only when in LOCKED, the reference is 000001, and the sample is 000000 (matching).
REQ-028 err_count SHALL saturate at 2^ERR_W-1; when err_clr and an increment coincide, the clear SHALL win (result 0).

Reset
REQ-029 reset SHALL dominate all inputs, including cen, load, and err_clr.
REQ-030 reset SHALL force the FSM to HUNT, the reference to 000000, and the match count to 0.
REQ-031 reset SHALL force the outputs to locked=0, index=0, invalid=0, err=0, wrap=0, and err_count=0.
REQ-032 reset asserted mid-lock SHALL drop locked on the next edge; relocking SHALL require the full HUNT->VERIFY->LOCKED path.

Verification
REQ-033 Lock: reset, then cen=1 with 000000, 100000, 110000 -> locked=1 after the third sample (LOCK_CNT=2); index=2.
REQ-034 Wrap: while locked, feed 000011, 000001, 000000 -> wrap pulses once, one cycle after the 000000 sample; index=0.
REQ-035 Break: while locked at 111000, feed 111110 -> err=1 for one cycle, err_count=1, locked=0, FSM in HUNT.
REQ-036 Illegal: feed 101010 in HUNT -> invalid pulses, index unchanged; feed 010000 while locked -> invalid=1, err=1, locked=0.
REQ-037 Load: while locked at 111100, load=1 with 000111 -> no err, locked=0, VERIFY entered; then 000011, 000001 -> locked=1.
REQ-038 Saturation and clear: ERR_W=2, four breaks -> err_count=3; err_clr coinciding with a fifth break -> err_count=0.

Source files
------------

// File: rtl/johnson_seq_checker.sv
// johnson_seq_checker: watches a 6-bit twisted-ring counter, locks onto its
// sequence and flags illegal codes, sequence breaks and wrap-arounds.
module johnson_seq_checker #(
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cen,
  input  logic             load,
  input  logic [5:0]       count_in,
  input  logic             err_clr,
  output logic             locked,
  output logic [3:0]       index,
  output logic             invalid,
  output logic             err,
  output logic             wrap,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;
  localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);

  logic [1:0]       state_q, state_d;
  logic [5:0]       ref_q, ref_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       index_q, index_d;
  logic             invalid_q, invalid_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;

  logic             legal;
  logic [3:0]       pos;
  logic [5:0]       nxt;
  logic             match;
  logic [3:0]       cnt_inc;

  // Decode the sample into legal/position and compare against the expected successor
  always_comb begin
    legal = 1'b1;
    pos   = 4'd0;
    case (count_in)
      6'b000000: pos = 4'd0;
      6'b100000: pos = 4'd1;
      6'b110000: pos = 4'd2;
      6'b111000: pos = 4'd3;
      6'b111100: pos = 4'd4;
      6'b111110: pos = 4'd5;
      6'b111111: pos = 4'd6;
      6'b011111: pos = 4'd7;
      6'b001111: pos = 4'd8;
      6'b000111: pos = 4'd9;
      6'b000011: pos = 4'd10;
      6'b000001: pos = 4'd11;
      default:   legal = 1'b0;
    endcase
    nxt     = {~ref_q[0], ref_q[5:1]};
    match   = legal && (count_in == nxt);
    cnt_inc = cnt_q + 4'd1;
  end

  // Next-state logic: HUNT/VERIFY/LOCKED tracking, with load forcing resync
  always_comb begin
    state_d     = state_q;
    ref_d       = ref_q;
    cnt_d       = cnt_q;
    index_d     = index_q;
    invalid_d   = 1'b0;
    err_d       = 1'b0;
    wrap_d      = 1'b0;
    err_count_d = err_count_q;
    if (cen) begin
      invalid_d = ~legal;
      if (legal) begin
        index_d = pos;
        ref_d   = count_in;
      end
      if (load) begin
        state_d = legal ? VERIFY : HUNT;
        if (legal) cnt_d = 4'd0;
      end else begin
        case (state_q)
          VERIFY: begin
            if (!legal) begin
              state_d = HUNT;
            end else if (match) begin
              cnt_d = cnt_inc;
              if (cnt_inc >= LOCK_C) state_d = LOCKED;
            end else begin
              cnt_d = 4'd0;
            end
          end
          LOCKED: begin
            if (match) begin
              wrap_d = (ref_q == 6'b000001);
            end else begin
              err_d   = 1'b1;
              state_d = HUNT;
            end
          end
          default: begin
            if (legal) begin
              state_d = VERIFY;
              cnt_d   = 4'd0;
            end
          end
        endcase
      end
    end
    if (err_d && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
    if (err_clr) err_count_d = '0;
  end

  // State and output registers; reset dominates everything
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HUNT;
      ref_q       <= 6'b000000;
      cnt_q       <= 4'd0;
      index_q     <= 4'd0;
      invalid_q   <= 1'b0;
      err_q       <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ref_q       <= ref_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      invalid_q   <= invalid_d;
      err_q       <= err_d;
      wrap_q      <= wrap_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign index     = index_q;
  assign invalid   = invalid_q;
  assign err       = err_q;
  assign wrap      = wrap_q;
  assign err_count = err_count_q;

endmodule
